// File: rtl/draw_sprite_pipe.sv
// Sprite overlay stage for the VGA pixel chain: fetches an SPR_W x SPR_H sprite from a
// synchronous ROM and composites it onto the timing/rgb stream with LAT = 2+ROM_LAT.
module draw_sprite_pipe #(
    parameter int          SPR_W      = 48,
    parameter int          SPR_H      = 64,
    parameter int          ADDR_W     = 16,
    parameter int          ROM_LAT    = 1,
    parameter int          SCALE_LOG2 = 0,
    parameter int          KEY_EN     = 1,
    parameter logic [11:0] KEY_COLOR  = 12'hF0F
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              spr_en,
    input  logic [11:0]       vcount_in,
    input  logic [11:0]       hcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [11:0]       rgb_pixel,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [11:0]       vcount_out,
    output logic [11:0]       hcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [11:0]       rgb_out
);

    // On-screen sprite footprint; 13 bits so x_act + width never wraps.
    localparam logic [12:0] SCR_W = 13'(SPR_W << SCALE_LOG2);
    localparam logic [12:0] SCR_H = 13'(SPR_H << SCALE_LOG2);

    typedef struct packed {
        logic        hit;
        logic [11:0] vcount;
        logic [11:0] hcount;
        logic        vsync;
        logic        vblnk;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } stage_t;

    logic [11:0] x_act, y_act;
    logic        en_act, vblnk_r;

    // Position/enable only take effect on the first cycle of vertical blanking.
    always_ff @(posedge pclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            x_act   <= '0;
            y_act   <= '0;
            en_act  <= 1'b0;
            vblnk_r <= 1'b0;
        end else begin
            vblnk_r <= vblnk_in;
            if (vblnk_in && !vblnk_r) begin
                x_act  <= xpos;
                y_act  <= ypos;
                en_act <= spr_en;
            end
        end
    end

    logic [11:0]       dx, dy, col, row;
    logic              hit_c;
    logic [ADDR_W-1:0] addr_c;
    stage_t            s1_c;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no latch can be inferred.
        s1_c   = '0;
        addr_c = '0;
        dx     = hcount_in - x_act;
        dy     = vcount_in - y_act;
        col    = dx >> SCALE_LOG2;
        row    = dy >> SCALE_LOG2;
        hit_c  = en_act && !hblnk_in && !vblnk_in
                 && ({1'b0, hcount_in} >= {1'b0, x_act})
                 && ({1'b0, hcount_in} <  ({1'b0, x_act} + SCR_W))
                 && ({1'b0, vcount_in} >= {1'b0, y_act})
                 && ({1'b0, vcount_in} <  ({1'b0, y_act} + SCR_H));
        if (hit_c)
            addr_c = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
        s1_c.hit    = hit_c;
        s1_c.vcount = vcount_in;
        s1_c.hcount = hcount_in;
        s1_c.vsync  = vsync_in;
        s1_c.vblnk  = vblnk_in;
        s1_c.hsync  = hsync_in;
        s1_c.hblnk  = hblnk_in;
        s1_c.rgb    = rgb_in;
    end

    // pipe[0] is stage 1 (aligned with pixel_addr); pipe[ROM_LAT] is aligned with rgb_pixel.
    stage_t pipe [ROM_LAT+1];

    always_ff @(posedge pclk) begin
        // NOTE: the pipeline is reset on purpose so a mid-frame reset flushes stale pixels.
        if (rst) begin
            pixel_addr <= '0;
            for (int i = 0; i <= ROM_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pixel_addr <= addr_c;
            pipe[0]    <= s1_c;
            for (int i = 1; i <= ROM_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    logic keyed;
    assign keyed = (KEY_EN != 0) && (rgb_pixel == KEY_COLOR);

    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_out <= pipe[ROM_LAT].vcount;
            hcount_out <= pipe[ROM_LAT].hcount;
            vsync_out  <= pipe[ROM_LAT].vsync;
            vblnk_out  <= pipe[ROM_LAT].vblnk;
            hsync_out  <= pipe[ROM_LAT].hsync;
            hblnk_out  <= pipe[ROM_LAT].hblnk;
            rgb_out    <= (pipe[ROM_LAT].hit && !keyed) ? rgb_pixel : pipe[ROM_LAT].rgb;
        end
    end

endmodule
